// File: rtl/sram_bus_pkg.sv
// Shared constants and types for the two-master SRAM bus arbiter.
//   Bus widths, rw encoding, FSM state encoding, timeout fill value and
//   the request payload carried from a master onto the slave bus.
package sram_bus_pkg;

   localparam int unsigned ADDR_WIDTH     = 19;
   localparam int unsigned DATA_WIDTH     = 16;
   localparam int unsigned BE_WIDTH       = 2;
   localparam int unsigned TIMEOUT_CYCLES = 16;
   localparam int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES);

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [DATA_WIDTH-1:0] TIMEOUT_FILL = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // One bus request as presented on the slave side.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] address;
      logic [BE_WIDTH-1:0]   byte_enable;
      logic                  rw;
      logic [DATA_WIDTH-1:0] write_data;
   } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick (combinational).
//   req        : request vector, bit N = master N
//   last_grant : index of the master granted most recently
//   winner_c   : one-hot winner, 00 when nobody requests
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] winner_c
);

   // On a tie the master that was not served last wins.
   always_comb begin
      winner_c = req;
      if (req == 2'b11) begin
         winner_c = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single SRAM controller port.
//   clk_clk/reset_reset : clock, synchronous active-high reset
//   m0_* / m1_*         : master request buses, ack pulse and read data back
//   s_*                 : registered request to the SRAM controller, ack/data in
//   grant               : one-hot owner of the current transaction
//   timeout_error       : sticky, set when an access is force-completed
module sram_bus_arbiter
   import sram_bus_pkg::*;
(
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic                  m0_bus_enable,
   input  logic [BE_WIDTH-1:0]   m0_byte_enable,
   input  logic                  m0_rw,
   input  logic [DATA_WIDTH-1:0] m0_write_data,
   output logic                  m0_acknowledge,
   output logic [DATA_WIDTH-1:0] m0_read_data,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic                  m1_bus_enable,
   input  logic [BE_WIDTH-1:0]   m1_byte_enable,
   input  logic                  m1_rw,
   input  logic [DATA_WIDTH-1:0] m1_write_data,
   output logic                  m1_acknowledge,
   output logic [DATA_WIDTH-1:0] m1_read_data,
   output logic [ADDR_WIDTH-1:0] s_address,
   output logic                  s_bus_enable,
   output logic [BE_WIDTH-1:0]   s_byte_enable,
   output logic                  s_rw,
   output logic [DATA_WIDTH-1:0] s_write_data,
   input  logic                  s_acknowledge,
   input  logic [DATA_WIDTH-1:0] s_read_data,
   output logic [1:0]            grant,
   output logic                  timeout_error
);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   bus_req_t              req_q, req_d;
   logic                  sbe_q, sbe_d;
   logic [1:0]            grant_q, grant_d;
   logic                  last_q, last_d;
   logic [1:0]            ack_q, ack_d;
   logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic                  terr_q, terr_d;

   logic [1:0]            winner_c;
   bus_req_t              m0_req_c, m1_req_c;
   logic                  timed_out_c;
   logic [DATA_WIDTH-1:0] fill_c;

   assign m0_req_c = '{address: m0_address, byte_enable: m0_byte_enable,
                       rw: m0_rw, write_data: m0_write_data};
   assign m1_req_c = '{address: m1_address, byte_enable: m1_byte_enable,
                       rw: m1_rw, write_data: m1_write_data};

   rr_arbiter2 u_rr (
      .req        ({m1_bus_enable, m0_bus_enable}),
      .last_grant (last_q),
      .winner_c   (winner_c)
   );

   // An acknowledge in the last allowed cycle still counts as a normal completion.
   assign timed_out_c = !s_acknowledge && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
   assign fill_c      = s_acknowledge ? s_read_data : TIMEOUT_FILL;

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      sbe_d   = sbe_q;
      grant_d = grant_q;
      last_d  = last_q;
      ack_d   = 2'b00;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      terr_d  = terr_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (winner_c != 2'b00) begin
               req_d   = winner_c[1] ? m1_req_c : m0_req_c;
               sbe_d   = 1'b1;
               grant_d = winner_c;
               last_d  = winner_c[1];
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (s_acknowledge || timed_out_c) begin
               // Read data (or the timeout fill) only lands for reads.
               if (req_q.rw == RW_READ) begin
                  if (grant_q[0]) rd0_d = fill_c;
                  if (grant_q[1]) rd1_d = fill_c;
               end
               ack_d    = grant_q;
               sbe_d    = 1'b0;
               req_d.rw = RW_READ;
               grant_d  = 2'b00;
               if (timed_out_c) terr_d = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '{address: '0, byte_enable: '0, rw: RW_READ, write_data: '0};
         sbe_q   <= 1'b0;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
         ack_q   <= 2'b00;
         rd0_q   <= '0;
         rd1_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         sbe_q   <= sbe_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         terr_q  <= terr_d;
      end
   end

   assign s_address      = req_q.address;
   assign s_byte_enable  = req_q.byte_enable;
   assign s_rw           = req_q.rw;
   assign s_write_data   = req_q.write_data;
   assign s_bus_enable   = sbe_q;
   assign grant          = grant_q;
   assign m0_acknowledge = ack_q[0];
   assign m1_acknowledge = ack_q[1];
   assign m0_read_data   = rd0_q;
   assign m1_read_data   = rd1_q;
   assign timeout_error  = terr_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
//   A behavioural SRAM controller acknowledges combinationally once the
//   access has been open for ack_delay cycles (never when ack_never is set).
module tb_sram_bus_arbiter;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic [18:0] m0_address, m1_address;
   logic        m0_bus_enable, m1_bus_enable;
   logic [1:0]  m0_byte_enable, m1_byte_enable;
   logic        m0_rw, m1_rw;
   logic [15:0] m0_write_data, m1_write_data;
   logic        m0_acknowledge, m1_acknowledge;
   logic [15:0] m0_read_data, m1_read_data;
   logic [18:0] s_address;
   logic        s_bus_enable;
   logic [1:0]  s_byte_enable;
   logic        s_rw;
   logic [15:0] s_write_data;
   logic        s_acknowledge;
   logic [15:0] s_read_data;
   logic [1:0]  grant;
   logic        timeout_error;

   int          checks = 0;
   int          failures = 0;
   int          wait_cnt = 0;
   int          ack_delay = 0;
   logic        ack_never = 1'b0;
   logic [15:0] slave_rdata = 16'h0000;

   always #5 clk_clk = ~clk_clk;

   sram_bus_arbiter dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .m0_address(m0_address), .m0_bus_enable(m0_bus_enable),
      .m0_byte_enable(m0_byte_enable), .m0_rw(m0_rw),
      .m0_write_data(m0_write_data), .m0_acknowledge(m0_acknowledge),
      .m0_read_data(m0_read_data),
      .m1_address(m1_address), .m1_bus_enable(m1_bus_enable),
      .m1_byte_enable(m1_byte_enable), .m1_rw(m1_rw),
      .m1_write_data(m1_write_data), .m1_acknowledge(m1_acknowledge),
      .m1_read_data(m1_read_data),
      .s_address(s_address), .s_bus_enable(s_bus_enable),
      .s_byte_enable(s_byte_enable), .s_rw(s_rw),
      .s_write_data(s_write_data), .s_acknowledge(s_acknowledge),
      .s_read_data(s_read_data),
      .grant(grant), .timeout_error(timeout_error)
   );

   // Slave model: cycles the current access has been open.
   always @(posedge clk_clk) wait_cnt <= s_bus_enable ? wait_cnt + 1 : 0;
   assign s_acknowledge = s_bus_enable && !ack_never && (wait_cnt >= ack_delay);
   assign s_read_data   = slave_rdata;

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int acks;
   int regrants;

   initial begin
      reset_reset = 1'b1;
      m0_address = '0; m0_bus_enable = 1'b0; m0_byte_enable = 2'b11; m0_rw = 1'b1; m0_write_data = '0;
      m1_address = '0; m1_bus_enable = 1'b0; m1_byte_enable = 2'b11; m1_rw = 1'b1; m1_write_data = '0;
      tick();
      tick();
      chk("rst_sbe",   32'(s_bus_enable), 32'd0);
      chk("rst_srw",   32'(s_rw), 32'd1);
      chk("rst_saddr", 32'(s_address), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_acks",  32'({m1_acknowledge, m0_acknowledge}), 32'd0);
      chk("rst_terr",  32'(timeout_error), 32'd0);
      reset_reset = 1'b0;

      // m0 single read, immediate slave acknowledge
      slave_rdata = 16'hA5A5; ack_delay = 0;
      m0_address = 19'h00010; m0_byte_enable = 2'b11; m0_rw = 1'b1; m0_bus_enable = 1'b1;
      tick();
      chk("rd_sbe",   32'(s_bus_enable), 32'd1);
      chk("rd_grant", 32'(grant), 32'h1);
      chk("rd_saddr", 32'(s_address), 32'h10);
      chk("rd_early_ack", 32'(m0_acknowledge), 32'd0);
      tick();
      chk("rd_ack",   32'(m0_acknowledge), 32'd1);
      chk("rd_data",  32'(m0_read_data), 32'hA5A5);
      chk("rd_m1ack", 32'(m1_acknowledge), 32'd0);
      chk("rd_sbe_drop", 32'(s_bus_enable), 32'd0);
      m0_bus_enable = 1'b0;
      tick();
      chk("rd_ack_pulse", 32'(m0_acknowledge), 32'd0);

      // m1 write with a 2-cycle slave delay
      ack_delay = 2;
      m1_address = 19'h7FFFF; m1_byte_enable = 2'b10; m1_rw = 1'b0; m1_write_data = 16'h1234;
      m1_bus_enable = 1'b1;
      tick();
      chk("wr_grant", 32'(grant), 32'h2);
      chk("wr_srw",   32'(s_rw), 32'd0);
      chk("wr_saddr", 32'(s_address), 32'h7FFFF);
      chk("wr_wdata", 32'(s_write_data), 32'h1234);
      chk("wr_sbe_lanes", 32'(s_byte_enable), 32'h2);
      m1_address = 19'h00001; m1_write_data = 16'hDEAD;
      tick();
      chk("wr_hold_addr", 32'(s_address), 32'h7FFFF);
      chk("wr_hold_data", 32'(s_write_data), 32'h1234);
      chk("wr_hold_rw",   32'(s_rw), 32'd0);
      tick();
      chk("wr_no_ack_yet", 32'(m1_acknowledge), 32'd0);
      tick();
      chk("wr_ack",     32'(m1_acknowledge), 32'd1);
      chk("wr_rw_back", 32'(s_rw), 32'd1);
      chk("wr_rdata_unch", 32'(m1_read_data), 32'd0);
      chk("wr_m0_rdata", 32'(m0_read_data), 32'hA5A5);
      m1_bus_enable = 1'b0;
      tick();

      // Fairness from reset: both request continuously
      reset_reset = 1'b1;
      tick();
      reset_reset = 1'b0;
      ack_delay = 0;
      m0_address = 19'h00100; m0_rw = 1'b1; m0_bus_enable = 1'b1;
      m1_address = 19'h00200; m1_rw = 1'b1; m1_bus_enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         slave_rdata = 16'h1000 + 16'(i);
         tick();
         chk("rr_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_saddr", 32'(s_address), (i % 2 == 0) ? 32'h100 : 32'h200);
         tick();
         chk("rr_ack", 32'({m1_acknowledge, m0_acknowledge}), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_rdata", (i % 2 == 0) ? 32'(m0_read_data) : 32'(m1_read_data), 32'h1000 + 32'(i));
         tick();
         chk("rr_turnaround", 32'({m1_acknowledge, m0_acknowledge, s_bus_enable}), 32'd0);
      end
      m0_bus_enable = 1'b0; m1_bus_enable = 1'b0;

      // Slave holds off the acknowledge for 5 cycles
      ack_delay = 5; slave_rdata = 16'hBEEF;
      m0_address = 19'h00055; m0_byte_enable = 2'b01; m0_rw = 1'b1; m0_bus_enable = 1'b1;
      tick();
      chk("wait_sbe", 32'(s_bus_enable), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("wait_hold", 32'({s_bus_enable, s_address, s_byte_enable}), 32'({1'b1, 19'h00055, 2'b01}));
         chk("wait_noack", 32'(m0_acknowledge), 32'd0);
      end
      tick();
      chk("wait_ack",   32'(m0_acknowledge), 32'd1);
      chk("wait_rdata", 32'(m0_read_data), 32'hBEEF);
      chk("wait_terr",  32'(timeout_error), 32'd0);
      m0_bus_enable = 1'b0;
      tick();

      // Slave never acknowledges: forced completion after 16 access cycles
      ack_never = 1'b1;
      m0_address = 19'h00066; m0_rw = 1'b1; m0_bus_enable = 1'b1;
      tick();
      chk("to_sbe", 32'(s_bus_enable), 32'd1);
      acks = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (m0_acknowledge) acks++;
      end
      chk("to_no_early_ack", 32'(acks), 32'd0);
      chk("to_terr_early",   32'(timeout_error), 32'd0);
      tick();
      chk("to_ack",   32'(m0_acknowledge), 32'd1);
      chk("to_rdata", 32'(m0_read_data), 32'hFFFF);
      chk("to_terr",  32'(timeout_error), 32'd1);
      chk("to_sbe_drop", 32'(s_bus_enable), 32'd0);
      m0_bus_enable = 1'b0;
      ack_never = 1'b0;
      tick();
      chk("to_sticky", 32'(timeout_error), 32'd1);

      // Reset in the middle of an m0 read
      ack_delay = 3;
      m0_address = 19'h00077; m0_bus_enable = 1'b1;
      tick();
      chk("ra_sbe", 32'(s_bus_enable), 32'd1);
      reset_reset = 1'b1;
      tick();
      chk("ra_sbe_drop", 32'(s_bus_enable), 32'd0);
      chk("ra_srw",      32'(s_rw), 32'd1);
      chk("ra_grant",    32'(grant), 32'd0);
      chk("ra_noack",    32'(m0_acknowledge), 32'd0);
      chk("ra_terr_clr", 32'(timeout_error), 32'd0);
      reset_reset = 1'b0;
      ack_delay = 0;
      m1_bus_enable = 1'b1;
      tick();
      chk("ra_tie_grant", 32'(grant), 32'h1);
      tick();
      chk("ra_tie_ack", 32'({m1_acknowledge, m0_acknowledge}), 32'h1);
      m0_bus_enable = 1'b0; m1_bus_enable = 1'b0;
      tick();

      // m0 drops its request during ACCESS
      ack_delay = 3;
      m0_address = 19'h00088; m0_bus_enable = 1'b1;
      tick();
      chk("drop_grant", 32'(grant), 32'h1);
      m0_bus_enable = 1'b0;
      acks = 0; regrants = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (m0_acknowledge) acks++;
         if (acks > 0 && grant != 2'b00) regrants++;
      end
      chk("drop_acks",    32'(acks), 32'd1);
      chk("drop_regrant", 32'(regrants), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
